softmax_exp_accum: RTL and testbench

Softmax stage directly downstream of the systolic odd-even sorter. On a start pulse it latches one row of ARRAYWIDTH signed output-buffer values plus the sorter's max_out. It streams one base-2 exponential estimate per cycle, e_k = ONE >> ((max - x_k) >> SCALE_SH), and accumulates their sum for the normalisation/divide stage that follows.

---
 rtl/softmax_exp_accum_pkg.sv | 18 +
 rtl/softmax_pow2_unit.sv | 29 ++
 rtl/softmax_exp_accum.sv | 150 +++++++++++++++
 tb/tb_softmax_exp_accum.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/softmax_exp_accum_pkg.sv
// Shared constants and types for the softmax exponential/accumulate stage.
package softmax_exp_accum_pkg;

    // Row geometry inherited from the output buffer / sorter configuration.
    localparam int unsigned ARRAYWIDTH_DEF      = 4;
    localparam int unsigned OUTPUT_BUF_DATASIZE = 8;

    // Softmax fixed-point constants.
    localparam int unsigned SOFTMAX_FRAC_W   = 7;
    localparam int unsigned SOFTMAX_SCALE_SH = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/softmax_pow2_unit.sv
// Combinational base-2 exponential estimate: e = ONE >> (clamp(d) >> SCALE_SH).
module softmax_pow2_unit
    import softmax_exp_accum_pkg::*;
#(
    parameter  int unsigned DW       = OUTPUT_BUF_DATASIZE,
    parameter  int unsigned FRAC_W   = SOFTMAX_FRAC_W,
    parameter  int unsigned SCALE_SH = SOFTMAX_SCALE_SH,
    localparam int unsigned EXP_W    = FRAC_W + 1
) (
    input  logic signed [DW:0]      d,
    output logic [EXP_W-1:0]        e_c
);

    localparam logic [EXP_W-1:0] ONE = EXP_W'(1) << FRAC_W;

    logic [DW:0] d_mag;
    logic [DW:0] d_sh;

    // Clamp negative differences, scale, then shift with saturation to zero.
    always_comb begin
        e_c   = '0;
        d_mag = d[DW] ? '0 : $unsigned(d);
        d_sh  = d_mag >> SCALE_SH;
        if (d_sh < (DW+1)'(EXP_W)) begin
            e_c = ONE >> d_sh;
        end
    end

endmodule

// File: rtl/softmax_exp_accum.sv
// Softmax stage: latches a sorted row and its max, streams base-2 exponentials
// one per cycle and accumulates their sum for the downstream divider.
module softmax_exp_accum
    import softmax_exp_accum_pkg::*;
#(
    parameter  int unsigned ARRAYWIDTH = ARRAYWIDTH_DEF,
    parameter  int unsigned DW         = OUTPUT_BUF_DATASIZE,
    parameter  int unsigned FRAC_W     = SOFTMAX_FRAC_W,
    parameter  int unsigned SCALE_SH   = SOFTMAX_SCALE_SH,
    localparam int unsigned IDXW       = $clog2(ARRAYWIDTH),
    localparam int unsigned EXP_W      = FRAC_W + 1,
    localparam int unsigned SUMW       = EXP_W + $clog2(ARRAYWIDTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ARRAYWIDTH*DW-1:0] row_in,
    input  logic [DW-1:0]            max_in,
    output logic                     busy,
    output logic                     exp_valid,
    output logic [IDXW-1:0]          exp_idx,
    output logic [EXP_W-1:0]         exp_out,
    output logic                     sum_valid,
    output logic [SUMW-1:0]          sum_out
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(ARRAYWIDTH - 1);

    state_t state;
    state_t next_state;

    logic [DW-1:0]        row_reg [ARRAYWIDTH];
    logic [DW-1:0]        max_reg;
    logic [IDXW-1:0]      idx;

    logic signed [DW:0]   d_reg;
    logic [IDXW-1:0]      d_idx;
    logic                 d_vld;

    logic                 accept;
    logic                 issue;
    logic                 last_issue;

    logic signed [DW:0]   max_ext;
    logic signed [DW:0]   x_ext;
    logic signed [DW:0]   diff;
    logic [EXP_W-1:0]     e_c;

    assign last_issue = (idx == LAST_IDX);
    assign max_ext    = {max_reg[DW-1], max_reg};
    assign x_ext      = {row_reg[idx][DW-1], row_reg[idx]};
    assign diff       = max_ext - x_ext;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        issue      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                issue = 1'b1;
                if (last_issue) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Exponential of the registered difference.
    softmax_pow2_unit #(
        .DW       (DW),
        .FRAC_W   (FRAC_W),
        .SCALE_SH (SCALE_SH)
    ) u_pow2 (
        .d   (d_reg),
        .e_c (e_c)
    );

    // Row latch, index counter, difference pipeline, outputs and accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(ARRAYWIDTH); k++) begin
                row_reg[k] <= '0;
            end
            max_reg   <= '0;
            idx       <= '0;
            d_reg     <= '0;
            d_idx     <= '0;
            d_vld     <= 1'b0;
            busy      <= 1'b0;
            exp_valid <= 1'b0;
            exp_idx   <= '0;
            exp_out   <= '0;
            sum_valid <= 1'b0;
            sum_out   <= '0;
        end else begin
            busy      <= (next_state != ST_IDLE);
            exp_valid <= d_vld;
            sum_valid <= 1'b0;

            if (accept) begin
                for (int k = 0; k < int'(ARRAYWIDTH); k++) begin
                    row_reg[k] <= row_in[k*DW +: DW];
                end
                max_reg <= max_in;
                idx     <= '0;
                sum_out <= '0;
            end

            if (issue) begin
                d_reg <= diff;
                d_idx <= idx;
                d_vld <= 1'b1;
                idx   <= last_issue ? '0 : idx + IDXW'(1);
            end else begin
                d_vld <= 1'b0;
            end

            // Retire one exponential; a new row is never accepted while one is retiring.
            if (d_vld) begin
                exp_idx   <= d_idx;
                exp_out   <= e_c;
                sum_out   <= sum_out + SUMW'(e_c);
                sum_valid <= (d_idx == LAST_IDX);
            end
        end
    end

endmodule

// File: tb/tb_softmax_exp_accum.sv
// Self-checking bench for softmax_exp_accum: directed table, random rows against
// an arithmetic reference, and hand sequences for busy/reset corner cases.
module tb_softmax_exp_accum;

    localparam int N  = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            start0, start1;
    logic [N*DW-1:0] row_in;
    logic [DW-1:0]   max_in;

    logic       busy      [2];
    logic       exp_valid [2];
    logic [1:0] exp_idx   [2];
    logic [7:0] exp_out   [2];
    logic       sum_valid [2];
    logic [9:0] sum_out   [2];

    int n_cmp = 0;
    int n_err = 0;

    softmax_exp_accum #(.ARRAYWIDTH(N), .DW(DW), .FRAC_W(7), .SCALE_SH(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .row_in(row_in), .max_in(max_in),
        .busy(busy[0]), .exp_valid(exp_valid[0]), .exp_idx(exp_idx[0]),
        .exp_out(exp_out[0]), .sum_valid(sum_valid[0]), .sum_out(sum_out[0])
    );

    softmax_exp_accum #(.ARRAYWIDTH(N), .DW(DW), .FRAC_W(7), .SCALE_SH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .row_in(row_in), .max_in(max_in),
        .busy(busy[1]), .exp_valid(exp_valid[1]), .exp_idx(exp_idx[1]),
        .exp_out(exp_out[1]), .sum_valid(sum_valid[1]), .sum_out(sum_out[1])
    );

    typedef struct packed {
        logic [N*DW-1:0]     row;
        logic [DW-1:0]       mx;
        logic                sel;
        logic [N-1:0][7:0]   e;
        logic [15:0]         sum;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start0 = v;
        else          start1 = v;
    endtask

    function automatic logic [N*DW-1:0] pack4(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    // Reference: e = 2^-(max-x scaled) in Q1.7, zero beyond the representable range.
    function automatic int ref_e(input logic [7:0] mx, input logic [7:0] x, input int sh);
        int d;
        d = int'($signed(mx)) - int'($signed(x));
        if (d < 0) d = 0;
        d = d >> sh;
        return (d >= 8) ? 0 : (128 >> d);
    endfunction

    // Start one row and check every output cycle-by-cycle; ends on the first idle
    // cycle so the next call's start lands exactly when busy has dropped.
    task automatic do_row(input int sel, input logic [N*DW-1:0] row, input logic [7:0] mx,
                          input logic [N-1:0][7:0] ee, input int es, input int inj_j,
                          input string nm);
        row_in = row;
        max_in = mx;
        set_start(sel, 1'b1);
        @(negedge clk);
        row_in = ~row;
        max_in = ~mx;
        for (int j = 0; j <= N + 1; j++) begin
            set_start(sel, 1'b0);
            chk({nm, ".busy"}, int'(busy[sel]), (j <= N) ? 1 : 0);
            chk({nm, ".exp_valid"}, int'(exp_valid[sel]), (j >= 2) ? 1 : 0);
            if (j >= 2) begin
                chk({nm, ".exp_idx"}, int'(exp_idx[sel]), j - 2);
                chk({nm, ".exp_out"}, int'(exp_out[sel]), int'(ee[j-2]));
            end
            chk({nm, ".sum_valid"}, int'(sum_valid[sel]), (j == N + 1) ? 1 : 0);
            if (j == N + 1) chk({nm, ".sum_out"}, int'(sum_out[sel]), es);
            if (j == inj_j) begin
                set_start(sel, 1'b1);
                row_in = $urandom;
                max_in = 8'($urandom);
            end
            if (j < N + 1) @(negedge clk);
        end
    endtask

    vec_t vecs [5];

    initial begin
        vec_t            v;
        logic [N*DW-1:0] r;
        logic [7:0]      m;
        logic [N-1:0][7:0] ee;
        int              es;
        int              sh;

        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; row_in = '0; max_in = '0;

        vecs[0] = '{row: pack4(10, 8, 3, -128), mx: 8'd10, sel: 1'b0,
                    e: {8'd0, 8'd1, 8'd32, 8'd128}, sum: 16'd161};
        vecs[1] = '{row: pack4(7, 5, 5, 5), mx: 8'd5, sel: 1'b0,
                    e: {8'd128, 8'd128, 8'd128, 8'd128}, sum: 16'd512};
        vecs[2] = '{row: pack4(4, 0, 2, 4), mx: 8'd4, sel: 1'b1,
                    e: {8'd128, 8'd64, 8'd32, 8'd128}, sum: 16'd352};
        vecs[3] = '{row: pack4(-5, -5, -5, -5), mx: 8'hFB, sel: 1'b0,
                    e: {8'd128, 8'd128, 8'd128, 8'd128}, sum: 16'd512};
        vecs[4] = '{row: pack4(127, -128, 126, 0), mx: 8'd127, sel: 1'b0,
                    e: {8'd0, 8'd64, 8'd0, 8'd128}, sum: 16'd192};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            chk("reset.busy", int'(busy[s]), 0);
            chk("reset.exp_valid", int'(exp_valid[s]), 0);
            chk("reset.exp_idx", int'(exp_idx[s]), 0);
            chk("reset.exp_out", int'(exp_out[s]), 0);
            chk("reset.sum_valid", int'(sum_valid[s]), 0);
            chk("reset.sum_out", int'(sum_out[s]), 0);
        end

        // Directed table, rows issued back-to-back.
        for (int i = 0; i < 5; i++) begin
            v = vecs[i];
            do_row(int'(v.sel), v.row, v.mx, v.e, int'(v.sum), -1, $sformatf("vec%0d", i));
        end

        // Start while busy is ignored; restart on first idle cycle is accepted.
        do_row(0, vecs[0].row, vecs[0].mx, vecs[0].e, int'(vecs[0].sum), 1, "busy_start");
        do_row(0, vecs[1].row, vecs[1].mx, vecs[1].e, int'(vecs[1].sum), -1, "after_busy");

        // Reset mid-row: outputs clear, no more pulses from the aborted row.
        @(negedge clk);
        row_in = vecs[0].row; max_in = vecs[0].mx; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst.pre_valid", int'(exp_valid[0]), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst.busy", int'(busy[0]), 0);
        chk("midrst.exp_valid", int'(exp_valid[0]), 0);
        chk("midrst.exp_out", int'(exp_out[0]), 0);
        chk("midrst.exp_idx", int'(exp_idx[0]), 0);
        chk("midrst.sum_valid", int'(sum_valid[0]), 0);
        chk("midrst.sum_out", int'(sum_out[0]), 0);
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            chk("midrst.quiet_valid", int'(exp_valid[0]), 0);
            chk("midrst.quiet_sum", int'(sum_valid[0]), 0);
        end
        do_row(0, vecs[4].row, vecs[4].mx, vecs[4].e, int'(vecs[4].sum), -1, "post_rst");

        // Reset and start together: reset wins.
        rst = 1'b1; start0 = 1'b1; row_in = vecs[0].row; max_in = vecs[0].mx;
        @(negedge clk);
        rst = 1'b0; start0 = 1'b0;
        chk("rst_start.busy", int'(busy[0]), 0);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("rst_start.exp_valid", int'(exp_valid[0]), 0);
        end

        // Random rows against the arithmetic reference on both scalings.
        for (int i = 0; i < 24; i++) begin
            sh = (i % 3 == 2) ? 1 : 0;
            r  = $urandom;
            m  = 8'sh80;
            for (int k = 0; k < N; k++) begin
                if ($signed(r[k*DW +: DW]) > $signed(m)) m = r[k*DW +: DW];
            end
            if ($urandom_range(0, 3) == 0) m = 8'($urandom);
            es = 0;
            for (int k = 0; k < N; k++) begin
                ee[k] = 8'(ref_e(m, r[k*DW +: DW], sh));
                es += ref_e(m, r[k*DW +: DW], sh);
            end
            do_row(sh, r, m, ee, es, -1, $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
